load_store_unit: RTL

//  Memory-stage controller between execute stage and data memory (Datmem).

---
 rtl/load_store_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Memory-stage load/store controller in front of a combinational-read data memory.
// Handles sub-word stores by read-modify-write and sign/zero-extends sub-word loads.
module load_store_unit #(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 32,
  parameter int WORD_ADDR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DWIDTH-1:0] resp_rdata,
  output logic              resp_err,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DWIDTH-1:0] mem_rdata
);

  localparam int NUM_LANES = DWIDTH / 8;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t            state, state_nxt;
  logic [1:0]        lat_lane;
  logic [1:0]        lat_size;
  logic              lat_signed;
  logic              lat_we;
  logic [15:0]       lat_wdata;
  logic              accept;
  logic              req_err;
  logic [AWIDTH-1:0] addr_calc;
  logic [DWIDTH-1:0] ld_ext;
  logic [DWIDTH-1:0] st_merge;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  assign accept    = req_valid && req_ready;
  assign req_err   = (req_size == 2'b11) ||
                     (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  assign addr_calc = (WORD_ADDR != 0) ? (req_addr >> 2) : {req_addr[AWIDTH-1:2], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) begin
               if (req_err)                        state_nxt = RESP;
               else if (req_we && req_size == 2'b10) state_nxt = WRITE;
               else                                state_nxt = READ;
             end
      READ:  state_nxt = lat_we ? WRITE : RESP;
      WRITE: state_nxt = RESP;
      RESP:  if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
  end

  // load extraction: byte lane addr[1:0], halfword lane addr[1]
  assign ld_byte = mem_rdata[{lat_lane, 3'b000} +: 8];
  assign ld_half = mem_rdata[{lat_lane[1], 4'b0000} +: 16];

  always_comb begin
    ld_ext = mem_rdata;
    case (lat_size)
      2'b00:   ld_ext = {{(DWIDTH-8){lat_signed & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{(DWIDTH-16){lat_signed & ld_half[15]}}, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  // per-lane merge of store data into the word read back from memory
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [1:0] LN = 2'(i);
    localparam int         HB = i % 2;
    logic sel;
    assign sel = (lat_size == 2'b00 && lat_lane == LN) ||
                 (lat_size == 2'b01 && lat_lane[1] == LN[1]);
    assign st_merge[8*i +: 8] = !sel ? mem_rdata[8*i +: 8] :
                                (lat_size == 2'b00) ? lat_wdata[7:0] : lat_wdata[8*HB +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_lane   <= '0;
      lat_size   <= '0;
      lat_signed <= 1'b0;
      lat_we     <= 1'b0;
      lat_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          lat_lane   <= req_addr[1:0];
          lat_size   <= req_size;
          lat_signed <= req_signed;
          lat_we     <= req_we;
          lat_wdata  <= req_wdata[15:0];
          resp_err   <= req_err;
          resp_rdata <= '0;
          if (!req_err) begin
            mem_addr <= addr_calc;
            if (req_we && req_size == 2'b10) begin
              mem_we    <= 1'b1;
              mem_wdata <= req_wdata;
            end
          end
        end
        READ: begin
          if (lat_we) begin
            mem_we    <= 1'b1;
            mem_wdata <= st_merge;
          end else begin
            resp_rdata <= ld_ext;
          end
        end
        WRITE:   mem_we <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
